// File: rtl/sdram_responder.sv
// sdram_responder: behavioural SDRAM device model.
// It decodes SDR SDRAM commands, keeps per-bank open-row state and a mode
// register, runs one read/write burst engine, and returns read data through
// a CAS-latency pipeline. Protocol violations are latched as sticky error flags.
module sdram_responder #(
    parameter int MEM_AW    = 12,
    parameter int CKE_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_ba,
    input  logic [15:0] sdram_dq_in,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        mode_valid,
    output logic [15:0] refresh_cnt,
    output logic [3:0]  err
);

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_t;

    typedef enum logic [1:0] {
        BURST_IDLE  = 2'd0,
        BURST_READ  = 2'd1,
        BURST_WRITE = 2'd2
    } burst_state_t;

    // Burst-length code to beat count; reserved codes behave as BL1.
    function automatic logic [3:0] bl_decode(input logic [2:0] code);
        case (code)
            3'd0:    return 4'd1;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    // CAS latency code; only 2 and 3 are modelled, anything else means 3.
    function automatic logic [1:0] cl_decode(input logic [2:0] code);
        case (code)
            3'd2:    return 2'd2;
            3'd3:    return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

    // Next column of a burst, wrapping inside the BL-aligned block.
    function automatic logic [9:0] next_col(input logic [9:0] col, input logic [3:0] bl);
        logic [9:0] mask;
        mask = {6'd0, bl - 4'd1};
        return (col & ~mask) | ((col + 10'd1) & mask);
    endfunction

    // Storage and control state
    logic [15:0]       mem_r [2**MEM_AW];
    logic [3:0]        bank_open_r;
    logic [2:0]        bank_row_r [4];
    logic              mode_valid_r;
    logic [3:0]        bl_r;
    logic [1:0]        cl_r;
    logic [15:0]       refresh_cnt_r;
    logic [3:0]        err_r;

    // Burst engine
    burst_state_t      burst_state_r, burst_state_nxt_s;
    logic [1:0]        burst_ba_r, burst_ba_nxt_s;
    logic [2:0]        burst_row_r, burst_row_nxt_s;
    logic [9:0]        burst_col_r, burst_col_nxt_s;
    logic [3:0]        burst_left_r, burst_left_nxt_s;

    // CAS pipeline and read data outputs
    logic [2:0]        pipe_vld_r;
    logic [MEM_AW-1:0] pipe_idx_r [3];
    logic              dq_oe_r;
    logic [15:0]       dq_out_r;

    // Combinational helpers
    cmd_t              cmd_s;
    logic              rw_ok_s;
    logic              pre_hit_s;
    logic              beat_vld_s;
    logic              beat_write_s;
    logic [1:0]        beat_ba_s;
    logic [2:0]        beat_row_s;
    logic [9:0]        beat_col_s;
    logic [MEM_AW-1:0] beat_idx_s;
    logic              wr_en_s;
    logic              sel_vld_s;
    logic [MEM_AW-1:0] sel_idx_s;
    logic              unused_s;

    // Command decode: nothing is decoded while the clock is disabled or chip deselected.
    always_comb begin
        cmd_s = CMD_NOP;
        if (!sdram_cs_n && sdram_cke) begin
            cmd_s = cmd_t'({sdram_ras_n, sdram_cas_n, sdram_we_n});
        end else begin
            cmd_s = CMD_NOP;
        end
    end

    assign rw_ok_s   = ((cmd_s == CMD_RD) || (cmd_s == CMD_WR)) && mode_valid_r
                       && bank_open_r[sdram_ba];
    assign pre_hit_s = (cmd_s == CMD_PRE) && (sdram_a[10] || (sdram_ba == burst_ba_r));

    // Burst FSM next state and per-cycle beat generation.
    always_comb begin
        burst_state_nxt_s = burst_state_r;
        burst_ba_nxt_s    = burst_ba_r;
        burst_row_nxt_s   = burst_row_r;
        burst_col_nxt_s   = burst_col_r;
        burst_left_nxt_s  = burst_left_r;
        beat_vld_s        = 1'b0;
        beat_write_s      = 1'b0;
        beat_ba_s         = burst_ba_r;
        beat_row_s        = burst_row_r;
        beat_col_s        = burst_col_r;
        if (!sdram_cke) begin
            burst_state_nxt_s = burst_state_r;
        end else if (rw_ok_s) begin
            // A new accepted READ/WRITE replaces any burst in progress.
            beat_vld_s        = 1'b1;
            beat_write_s      = (cmd_s == CMD_WR);
            beat_ba_s         = sdram_ba;
            beat_row_s        = bank_row_r[sdram_ba];
            beat_col_s        = sdram_a[9:0];
            burst_ba_nxt_s    = sdram_ba;
            burst_row_nxt_s   = bank_row_r[sdram_ba];
            burst_col_nxt_s   = next_col(sdram_a[9:0], bl_r);
            burst_left_nxt_s  = bl_r - 4'd1;
            if (bl_r == 4'd1) begin
                burst_state_nxt_s = BURST_IDLE;
            end else if (cmd_s == CMD_WR) begin
                burst_state_nxt_s = BURST_WRITE;
            end else begin
                burst_state_nxt_s = BURST_READ;
            end
        end else begin
            case (burst_state_r)
                BURST_READ, BURST_WRITE: begin
                    if (pre_hit_s) begin
                        burst_state_nxt_s = BURST_IDLE;
                    end else begin
                        beat_vld_s       = 1'b1;
                        beat_write_s     = (burst_state_r == BURST_WRITE);
                        burst_col_nxt_s  = next_col(burst_col_r, bl_r);
                        burst_left_nxt_s = burst_left_r - 4'd1;
                        if ((cmd_s == CMD_BST) || (burst_left_r == 4'd1)) begin
                            burst_state_nxt_s = BURST_IDLE;
                        end else begin
                            burst_state_nxt_s = burst_state_r;
                        end
                    end
                end
                default: burst_state_nxt_s = BURST_IDLE;
            endcase
        end
    end

    assign beat_idx_s = MEM_AW'({beat_ba_s, beat_row_s, beat_col_s[6:0]});
    assign wr_en_s    = beat_vld_s && beat_write_s;

    // Pick the pipeline stage matching the programmed CAS latency.
    always_comb begin
        sel_vld_s = 1'b0;
        sel_idx_s = pipe_idx_r[2];
        if (cl_r == 2'd2) begin
            sel_vld_s = pipe_vld_r[1];
            sel_idx_s = pipe_idx_r[1];
        end else begin
            sel_vld_s = pipe_vld_r[2];
            sel_idx_s = pipe_idx_r[2];
        end
    end

    // Array write port: byte-masked beat writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            if (!sdram_dqml) mem_r[beat_idx_s][7:0]  <= sdram_dq_in[7:0];
            if (!sdram_dqmh) mem_r[beat_idx_s][15:8] <= sdram_dq_in[15:8];
        end
    end

    // Control state, burst registers, CAS pipeline, read outputs and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open_r   <= 4'b0000;
            for (int i = 0; i < 4; i++) bank_row_r[i] <= 3'd0;
            mode_valid_r  <= 1'b0;
            bl_r          <= 4'd1;
            cl_r          <= 2'd3;
            refresh_cnt_r <= 16'd0;
            err_r         <= 4'b0000;
            burst_state_r <= BURST_IDLE;
            burst_ba_r    <= 2'd0;
            burst_row_r   <= 3'd0;
            burst_col_r   <= 10'd0;
            burst_left_r  <= 4'd0;
            pipe_vld_r    <= 3'b000;
            for (int i = 0; i < 3; i++) pipe_idx_r[i] <= '0;
            dq_oe_r       <= 1'b0;
            dq_out_r      <= 16'h0000;
        end else begin
            burst_state_r <= burst_state_nxt_s;
            burst_ba_r    <= burst_ba_nxt_s;
            burst_row_r   <= burst_row_nxt_s;
            burst_col_r   <= burst_col_nxt_s;
            burst_left_r  <= burst_left_nxt_s;
            if (sdram_cke) begin
                pipe_vld_r    <= {pipe_vld_r[1:0], beat_vld_s && !beat_write_s};
                pipe_idx_r[0] <= beat_idx_s;
                pipe_idx_r[1] <= pipe_idx_r[0];
                pipe_idx_r[2] <= pipe_idx_r[1];
                dq_oe_r       <= sel_vld_s;
                dq_out_r      <= sel_vld_s ? mem_r[sel_idx_s] : 16'h0000;
            end
            case (cmd_s)
                CMD_LMR: begin
                    bl_r         <= bl_decode(sdram_a[2:0]);
                    cl_r         <= cl_decode(sdram_a[6:4]);
                    mode_valid_r <= 1'b1;
                end
                CMD_REF: begin
                    refresh_cnt_r <= refresh_cnt_r + 16'd1;
                    if (|bank_open_r) err_r[0] <= 1'b1;
                end
                CMD_PRE: begin
                    if (sdram_a[10]) bank_open_r <= 4'b0000;
                    else             bank_open_r[sdram_ba] <= 1'b0;
                end
                CMD_ACT: begin
                    if (!mode_valid_r) begin
                        err_r[2] <= 1'b1;
                    end else begin
                        if (bank_open_r[sdram_ba]) err_r[0] <= 1'b1;
                        bank_open_r[sdram_ba] <= 1'b1;
                        bank_row_r[sdram_ba]  <= sdram_a[2:0];
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!mode_valid_r)               err_r[2] <= 1'b1;
                    else if (!bank_open_r[sdram_ba]) err_r[1] <= 1'b1;
                end
                default: begin
                end
            endcase
            if ((CKE_CHECK != 0) && !sdram_cke && !sdram_cs_n
                && ({sdram_ras_n, sdram_cas_n, sdram_we_n} != 3'b111)) begin
                err_r[3] <= 1'b1;
            end
        end
    end

    // Address bits the array does not resolve.
    assign unused_s = &{1'b0, sdram_a[12:11], sdram_a[3], beat_col_s[9:7], 1'b0};

    assign sdram_dq_out = dq_out_r;
    assign sdram_dq_oe  = dq_oe_r;
    assign mode_valid   = mode_valid_r;
    assign refresh_cnt  = refresh_cnt_r;
    assign err          = err_r;

endmodule
